// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and arithmetic helpers for the SNN tile
package snn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Unsigned add of two w-bit values, clamped to 2^w-1 instead of wrapping (w <= 31).
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] s;
    logic [32:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (33'd1 << w) - 33'd1;
    return (s > lim) ? lim[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/lif_update_core.sv
// rtl/lif_update_core.sv - combinational leaky-integrate-fire update for one neuron
module lif_update_core
  import snn_pkg::*;
#(
  parameter int W  = 8,
  parameter int RW = 8
) (
  input  logic [W-1:0]  v,
  input  logic [RW-1:0] count,
  input  logic [W-1:0]  current,
  input  logic [W-1:0]  threshold,
  input  logic [W-1:0]  leak,
  input  logic [RW-1:0] refrac_period,
  output logic [W-1:0]  v_next,
  output logic [RW-1:0] count_next,
  output logic          spike
);

  logic [W-1:0] sum;

  always_comb begin
    sum        = W'(sat_add(32'(v), 32'(current), W));
    v_next     = v;
    count_next = count;
    spike      = 1'b0;
    if (count != '0) begin
      // Refractory: input current is dropped and the membrane is frozen.
      count_next = count - 1'b1;
    end else if (sum >= threshold) begin
      spike      = 1'b1;
      v_next     = '0;
      count_next = refrac_period;
    end else begin
      v_next = (sum > leak) ? (sum - leak) : '0;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - N LIF neurons sharing one time-multiplexed update datapath
module lif_neuron_array
  import snn_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int RW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           step,
  input  logic [N*W-1:0] current,
  input  logic [W-1:0]   threshold,
  input  logic [W-1:0]   leak_rate,
  input  logic [RW-1:0]  refrac_period,
  output logic           busy,
  output logic           spike_valid,
  output logic [N-1:0]   spikes,
  output logic           overrun
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_t         state;
  logic [IW-1:0]  idx;
  logic [N*W-1:0] cur_sh;
  logic [W-1:0]   thr_sh;
  logic [W-1:0]   leak_sh;
  logic [RW-1:0]  rp_sh;
  logic [W-1:0]   v_mem   [N];
  logic [RW-1:0]  cnt_mem [N];
  logic [N-1:0]   spike_acc;
  logic [N-1:0]   acc_next;

  logic [W-1:0]   v_nxt;
  logic [RW-1:0]  cnt_nxt;
  logic           spk;

  lif_update_core #(.W(W), .RW(RW)) u_core (
    .v             (v_mem[idx]),
    .count         (cnt_mem[idx]),
    .current       (cur_sh[idx*W +: W]),
    .threshold     (thr_sh),
    .leak          (leak_sh),
    .refrac_period (rp_sh),
    .v_next        (v_nxt),
    .count_next    (cnt_nxt),
    .spike         (spk)
  );

  always_comb begin
    acc_next      = spike_acc;
    acc_next[idx] = spk;
  end

  assign busy    = (state != ST_IDLE);
  assign overrun = step && (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cur_sh      <= '0;
      thr_sh      <= '0;
      leak_sh     <= '0;
      rp_sh       <= '0;
      spike_acc   <= '0;
      spikes      <= '0;
      spike_valid <= 1'b0;
      for (int k = 0; k < N; k++) begin
        v_mem[k]   <= '0;
        cnt_mem[k] <= '0;
      end
    end else begin
      spike_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (step) begin
            cur_sh  <= current;
            thr_sh  <= threshold;
            leak_sh <= leak_rate;
            rp_sh   <= refrac_period;
            idx     <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          v_mem[idx]   <= v_nxt;
          cnt_mem[idx] <= cnt_nxt;
          spike_acc    <= acc_next;
          if (idx == LAST) begin
            // Publish at the edge entering DONE so spikes and strobe line up.
            idx         <= '0;
            spikes      <= acc_next;
            spike_valid <= 1'b1;
            state       <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - scoreboard bench for lif_neuron_array
module tb_lif_neuron_array;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int RW = 8;
  localparam int VMAX = (1 << W) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           step = 1'b0;
  logic [N*W-1:0] current = '0;
  logic [W-1:0]   threshold = '0;
  logic [W-1:0]   leak_rate = '0;
  logic [RW-1:0]  refrac_period = '0;
  logic           busy;
  logic           spike_valid;
  logic [N-1:0]   spikes;
  logic           overrun;

  lif_neuron_array #(.N(N), .W(W), .RW(RW)) dut (
    .clk           (clk),
    .reset         (reset),
    .step          (step),
    .current       (current),
    .threshold     (threshold),
    .leak_rate     (leak_rate),
    .refrac_period (refrac_period),
    .busy          (busy),
    .spike_valid   (spike_valid),
    .spikes        (spikes),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0]   sp;
    logic [N*W-1:0] pot;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mv[N];
  int   mc[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_clear();
    for (int k = 0; k < N; k++) begin
      mv[k] = 0;
      mc[k] = 0;
    end
  endfunction

  // One timestep of the reference neurons, straight from the LIF rules.
  function automatic logic [N-1:0] model_step(input logic [N*W-1:0] cur, input int thr,
                                              input int leak, input int rp);
    logic [N-1:0] s;
    int sum;
    s = '0;
    for (int k = 0; k < N; k++) begin
      if (mc[k] > 0) begin
        mc[k] = mc[k] - 1;
      end else begin
        sum = mv[k] + int'(cur[k*W +: W]);
        if (sum > VMAX) sum = VMAX;
        if (sum >= thr) begin
          s[k]  = 1'b1;
          mv[k] = 0;
          mc[k] = rp;
        end else begin
          mv[k] = (sum > leak) ? sum - leak : 0;
        end
      end
    end
    return s;
  endfunction

  function automatic logic [N*W-1:0] model_pot();
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = W'(mv[k]);
    return p;
  endfunction

  task automatic push_expect(input logic [N*W-1:0] cur, input logic [W-1:0] thr,
                             input logic [W-1:0] leak, input logic [RW-1:0] rp, input int at);
    exp_t e;
    e.sp  = model_step(cur, int'(thr), int'(leak), int'(rp));
    e.pot = model_pot();
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per spike_valid strobe.
  always @(negedge clk) begin
    exp_t e;
    logic [W-1:0] got;
    if (!reset && spike_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_strobe: got spike_valid at cycle %0d spikes=%b required none", cyc, spikes);
      end else begin
        e = exp_q.pop_front();
        chk("spikes", 64'(spikes), 64'(e.sp));
        chk("strobe_cycle", 64'(cyc), 64'(e.cyc));
        for (int k = 0; k < N; k++) begin
          got = dut.v_mem[k];
          chk($sformatf("potential[%0d]", k), 64'(got), 64'(e.pot[k*W +: W]));
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: got %0d pending strobes required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    exp_q.delete();
  endtask

  // Issue one timestep, then scramble the live inputs while the array is running.
  task automatic do_step(input logic [N*W-1:0] cur, input logic [W-1:0] thr,
                         input logic [W-1:0] leak, input logic [RW-1:0] rp);
    current = cur; threshold = thr; leak_rate = leak; refrac_period = rp;
    push_expect(cur, thr, leak, rp, cyc + N + 1);
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    for (int k = 0; k < N; k++) current[k*W +: W] = W'($urandom_range(0, VMAX));
    threshold     = W'($urandom_range(0, VMAX));
    leak_rate     = W'($urandom_range(0, VMAX));
    refrac_period = RW'($urandom_range(0, 5));
    drain();
  endtask

  function automatic logic [N*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {W'(d), W'(c), W'(b), W'(a)};
  endfunction

  initial begin
    logic [N*W-1:0] cur;
    int ov_cnt;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_valid", 64'(spike_valid), 64'(0));
    chk("reset_spikes", 64'(spikes), 64'(0));
    chk("reset_overrun", 64'(overrun), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // Latency and basic integration with leak.
    do_step(pack4(10, 20, 30, 40), 8'd100, 8'd1, 8'd2);

    // Threshold, refractory and recovery on neuron 0.
    apply_reset();
    repeat (6) do_step(pack4(60, 0, 0, 0), 8'd100, 8'd0, 8'd2);

    // Saturation: 250 + 200 clamps to 255 and still fires at threshold 255.
    apply_reset();
    do_step(pack4(250, 0, 5, 0), 8'd255, 8'd0, 8'd0);
    do_step(pack4(200, 0, 255, 0), 8'd255, 8'd0, 8'd0);

    // Leak floor.
    apply_reset();
    repeat (3) do_step(pack4(3, 3, 3, 3), 8'd100, 8'd5, 8'd0);

    // Zero threshold fires every non-refractory neuron.
    repeat (2) do_step(pack4(0, 7, 0, 255), 8'd0, 8'd0, 8'd0);

    // Randomized timesteps.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) cur[k*W +: W] = W'($urandom_range(0, 120));
      do_step(cur, W'($urandom_range(40, 255)), W'($urandom_range(0, 20)),
              RW'($urandom_range(0, 3)));
    end

    // Step held high: back-to-back timesteps every N+2 cycles, overrun while busy.
    cur = pack4(30, 45, 60, 90);
    current = cur; threshold = 8'd100; leak_rate = 8'd2; refrac_period = 8'd1;
    for (int j = 0; j < 3; j++)
      push_expect(cur, 8'd100, 8'd2, 8'd1, cyc + j * (N + 2) + N + 1);
    step = 1'b1;
    ov_cnt = 0;
    repeat (3 * (N + 2)) begin
      @(negedge clk);
      if (overrun) ov_cnt++;
      @(posedge clk); #1;
    end
    step = 1'b0;
    chk("overrun_pulses", 64'(ov_cnt), 64'(3 * (N + 1)));
    drain();
    repeat (2) @(posedge clk);
    #1;

    // Reset two cycles into a timestep aborts it and clears everything.
    current = pack4(90, 90, 90, 90); threshold = 8'd50; leak_rate = 8'd0; refrac_period = 8'd0;
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(spike_valid), 64'(0));
    for (int k = 0; k < N; k++) chk($sformatf("abort_pot[%0d]", k), 64'(dut.v_mem[k]), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
    exp_q.delete();
    repeat (N + 3) @(posedge clk);
    #1;
    do_step(pack4(10, 20, 30, 40), 8'd100, 8'd1, 8'd2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
